// File: rtl/regfile_pkg.sv
// Shared register-file constants and the dump-engine state type.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Sequential register-file read-out engine: walks first_reg..last_reg (wrapping)
// on one read port and offers each captured word on a valid/ready stream.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rn,
  input  logic [DATA_W-1:0] q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              busy,
  output logic              done
);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] oidx_q, oidx_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      oidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = first_reg;
          last_d  = last_reg;
          state_d = FETCH;
        end
      end
      FETCH: begin
        data_d  = q;
        oidx_d  = idx_q;
        valid_d = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (idx_q == last_q) begin
            state_d = DONE;
          end else begin
            // Natural ADDR_W-bit overflow provides the 31 -> 0 wrap.
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // idx_q only moves on an accepted start or a handshake, so it already holds in IDLE.
  assign rn        = idx_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = oidx_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
